// File: rtl/rr_arb_mux_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_mux_pkg
// Shared definitions for the round-robin / fixed-priority arbitrating mux.
//   arb_mode_e : arbitration mode encodings (MODE_FIXED, MODE_RR)
//   clog2()    : index-width helper, usable in parameter expressions
// ----------------------------------------------------------------------------
package rr_arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    // Smallest w such that 2**w >= value. Callers only pass value >= 2, so
    // the result is always at least 1 and a selector port is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage : rr_arb_mux_pkg

// File: rtl/rr_prio_enc.sv
// ----------------------------------------------------------------------------
// rr_prio_enc
// Combinational rotating priority encoder. Searches req upward starting at
// index 'start', wrapping modulo NUM_CH, and reports the first set bit.
// Ports:
//   req   in  NUM_CH  request vector, bit k = channel k
//   start in  IDX_W   index where the search begins (must be < NUM_CH)
//   grant out NUM_CH  one-hot grant for the winner, zero if no request
//   idx   out IDX_W   winner index, zero if no request
//   any   out 1       at least one request bit is set
// ----------------------------------------------------------------------------
module rr_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Candidate channel for this search step, wrapped into range.
            cand = int'(start) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule : rr_prio_enc

// File: rtl/rr_arb_mux.sv
// ----------------------------------------------------------------------------
// rr_arb_mux
// Arbitrating N:1 mux with a single registered output stage. Each cycle the
// stage is free (empty, or being drained) one requesting channel is granted
// and its word is captured; the grant is chosen by fixed priority (lowest
// index) or round-robin from rr_ptr.
// Ports:
//   clk       in  1              rising-edge clock
//   rst_n     in  1              asynchronous active-low reset
//   mode      in  1              0 = fixed priority, 1 = round-robin
//   in_valid  in  NUM_CH         per-channel request
//   in_data   in  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]
//   in_ready  out NUM_CH         one-hot accept for the winning channel
//   out_valid out 1              output register holds a word
//   out_data  out DATA_W         registered winning word
//   out_sel   out SEL_W          registered winning channel index
//   out_ready in  1              downstream accepts
// ----------------------------------------------------------------------------
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  start_idx;
    logic [SEL_W-1:0]  win_idx;
    logic [SEL_W-1:0]  ptr_next;
    logic [NUM_CH-1:0] win_grant;
    logic              win_any;
    logic              free;
    logic              accept;
    logic [DATA_W-1:0] win_data;

    // Fixed priority is simply a rotating search that always starts at 0,
    // so both modes share one encoder and mode changes act immediately.
    assign start_idx = (mode == MODE_RR) ? rr_ptr : '0;

    rr_prio_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SEL_W)
    ) u_prio_enc (
        .req   (in_valid),
        .start (start_idx),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The stage can take a word when it is empty or its word leaves this
    // cycle. Gating with rst_n keeps in_ready low during reset even though
    // the cleared out_valid would otherwise make the stage look free.
    assign free     = !out_valid || out_ready;
    assign in_ready = (rst_n && free) ? win_grant : '0;
    assign accept   = rst_n && free && win_any;

    // AND-OR mux keyed by the one-hot grant; avoids a variable part-select.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (win_grant[k]) begin
                win_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (win_idx == SEL_W'(NUM_CH - 1)) ? '0 : win_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win_idx;
        end else if (out_ready) begin
            // Drained with nothing behind it: data/sel keep last values.
            out_valid <= 1'b0;
        end
    end

    // The pointer advances on every accepted word in either mode, so a
    // switch to round-robin continues fairly from the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= ptr_next;
        end
    end

    a_in_ready_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

    a_hold_on_stall : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

    a_no_accept_on_stall : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |-> (in_ready == '0));

endmodule : rr_arb_mux

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb[$];   // {sel, data} of accepted words, in order
    logic       mv;
    logic [1:0] mptr;

    always #5 clk = ~clk;

    rr_arb_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_grant(input logic [3:0] req, input logic md,
                                            input logic [1:0] ptr);
        int s;
        int c;
        s = md ? int'(ptr) : 0;
        for (int i = 0; i < 4; i++) begin
            c = (s + i) % 4;
            if (req[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic pop_check(input string tag);
        logic [9:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(out_data), 32'(e[7:0]));
            chk({tag, "_sel"},  32'(out_sel),  32'(e[9:8]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] eg;
        logic       fr;
        int         cyc;

        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;

        // Reset values, before any clock edge, with requests pending.
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_sel",   32'(out_sel),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'b0000);
        tick();
        tick();
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_ready", 32'(in_ready),  32'b0000);

        // Round-robin from pointer 0: 0,1,2,3,0.
        mode  = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("rr_sel%0d", i),   32'(out_sel),   32'(i % 4));
            chk($sformatf("rr_data%0d", i),  32'(out_data),  32'(8'hA0 + (i % 4)));
        end
        chk("rr_ptr_after", 32'(dut.rr_ptr), 32'd1);

        // Fixed priority: ch1 always beats ch3.
        mode     = 1'b0;
        in_valid = 4'b1010;
        in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        #1;
        chk("fx_ready0", 32'(in_ready), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fx_sel%0d", i),   32'(out_sel),  32'd1);
            chk($sformatf("fx_data%0d", i),  32'(out_data), 32'h11);
            chk($sformatf("fx_ready%0d", i), 32'(in_ready), 32'b0010);
        end
        chk("fx_ptr", 32'(dut.rr_ptr), 32'd2);

        // Backpressure: 3 stalled cycles, then RR resumes from preserved ptr 2.
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b0;
        #1;
        chk("bp_ready_now", 32'(in_ready), 32'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_data%0d", i),  32'(out_data),  32'h11);
            chk($sformatf("bp_sel%0d", i),   32'(out_sel),   32'd1);
            chk($sformatf("bp_ready%0d", i), 32'(in_ready),  32'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("bp_release_sel",  32'(out_sel),  32'd2);
        chk("bp_release_data", 32'(out_data), 32'hA2);

        // Wrap/skip: ptr 3, requests on ch0 and ch2.
        chk("wr_ptr3", 32'(dut.rr_ptr), 32'd3);
        in_valid = 4'b0101;
        #1;
        chk("wr_ready_a", 32'(in_ready), 32'b0001);
        tick();
        chk("wr_sel_a",  32'(out_sel),    32'd0);
        chk("wr_data_a", 32'(out_data),   32'hA0);
        chk("wr_ptr1",   32'(dut.rr_ptr), 32'd1);
        #1;
        chk("wr_ready_b", 32'(in_ready), 32'b0100);
        tick();
        chk("wr_sel_b",  32'(out_sel),  32'd2);
        chk("wr_data_b", 32'(out_data), 32'hA2);

        // Drain with no requests: valid falls, data/sel and ptr hold.
        in_valid = 4'b0000;
        #1;
        chk("dr_ready", 32'(in_ready), 32'b0000);
        tick();
        chk("dr_valid", 32'(out_valid),  32'd0);
        chk("dr_data",  32'(out_data),   32'hA2);
        chk("dr_sel",   32'(out_sel),    32'd2);
        chk("dr_ptr",   32'(dut.rr_ptr), 32'd3);

        // Reset mid-stream while a word is held.
        in_valid = 4'b1000;
        tick();
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        chk("mr_pre_sel",   32'(out_sel),   32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid),  32'd0);
        chk("mr_data",  32'(out_data),   32'h00);
        chk("mr_sel",   32'(out_sel),    32'd0);
        chk("mr_ready", 32'(in_ready),   32'b0000);
        chk("mr_ptr",   32'(dut.rr_ptr), 32'd0);
        in_valid = 4'b0000;
        tick();
        rst_n = 1'b1;

        // Sweep: every request pattern in both modes against a scoreboard.
        mv   = 1'b0;
        mptr = 2'd0;
        cyc  = 0;
        for (int md = 0; md < 2; md++) begin
            for (int pat = 0; pat < 16; pat++) begin
                mode      = md[0];
                in_valid  = 4'(pat);
                out_ready = ((pat + md) % 3) != 0;
                for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = 8'(cyc * 4 + k);
                #1;
                fr = !mv || out_ready;
                eg = fr ? ref_grant(4'(pat), md[0], mptr) : 4'b0000;
                chk($sformatf("sw_ready_m%0d_p%0d", md, pat), 32'(in_ready), 32'(eg));
                chk($sformatf("sw_onehot_m%0d_p%0d", md, pat),
                    32'($countones(in_ready) <= 1), 32'd1);
                chk($sformatf("sw_valid_m%0d_p%0d", md, pat), 32'(out_valid), 32'(mv));
                if (mv && out_ready) pop_check($sformatf("sw_out_m%0d_p%0d", md, pat));
                if (eg != 4'b0000) begin
                    sb.push_back({oh_idx(eg), in_data[oh_idx(eg)*8 +: 8]});
                    mptr = oh_idx(eg) + 2'd1;
                    mv   = 1'b1;
                end else if (out_ready) begin
                    mv = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid) pop_check($sformatf("sw_drain%0d", i));
            tick();
        end
        chk("sw_final_valid", 32'(out_valid), 32'd0);
        chk("sw_sb_empty",    32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_arb_mux
